// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_pkg
// Description : Shared types and width helpers for the stochastic-to-binary
//               stream decoder.
//               - sc_state_t : decoder control states (idle / accumulating)
//               - count_w(n) : width of a count covering 0..2**n
//               - bip_w(n)   : width of a signed value covering -2**n..+2**n
// Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } sc_state_t;

  // One extra bit so a window of all ones (2**n) is representable.
  function automatic int count_w(input int n);
    return n + 1;
  endfunction

  // Twice the count minus 2**n needs one more bit than the count, as signed.
  function automatic int bip_w(input int n);
    return n + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : sc_window_counter
// Description : Sample and ones counters for one window of 2**N valid bits.
//               Ports:
//                 clk           - system clock, rising edge
//                 reset         - asynchronous active-low reset
//                 i_clr         - clear both counters (new window)
//                 i_en          - a valid bit is accepted this cycle
//                 i_bit_in      - stochastic bit being accepted
//                 o_done        - this cycle accepts the last bit of the window
//                 o_final_count - ones count including the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int N = 8,
  localparam int COUNT_W = count_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_bit_in,
  output logic               o_done,
  output logic [COUNT_W-1:0] o_final_count
);

  localparam logic [COUNT_W-1:0] c_last_sample = COUNT_W'((1 << N) - 1);

  logic [COUNT_W-1:0] r_samples;
  logic [COUNT_W-1:0] r_ones;

  assign o_done        = i_en && (r_samples == c_last_sample);
  assign o_final_count = r_ones + COUNT_W'(i_bit_in);

  // Completion restarts the window on its own, so the next valid bit is
  // always sample 0 of a fresh window regardless of what the top does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (i_clr || o_done) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (i_en) begin
      r_samples <= r_samples + COUNT_W'(1);
      r_ones    <= o_final_count;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sc_stream_decoder
// Description : Counts ones over windows of 2**N valid stochastic bits and
//               presents the result as unipolar count and bipolar value on a
//               valid/ready handshake. The result register is independent of
//               the window state machine, so a new window accumulates while
//               the previous result waits for the consumer.
//               Ports:
//                 clk         - system clock, rising edge
//                 reset       - asynchronous active-low reset
//                 start       - pulse: begin new window, clear overrun
//                 bit_in      - stochastic bit
//                 bit_valid   - bit_in is sampled this cycle
//                 out_count   - ones in the window, 0..2**N
//                 out_bipolar - 2*out_count - 2**N (signed)
//                 out_valid   - result register holds an unconsumed result
//                 out_ready   - consumer accepts the result
//                 busy        - window accumulation in progress
//                 overrun     - sticky: a completed window was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int N          = 8,
  parameter int CONTINUOUS = 0,
  localparam int COUNT_W = count_w(N),
  localparam int BIP_W   = bip_w(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic [COUNT_W-1:0]      out_count,
  output logic signed [BIP_W-1:0] out_bipolar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [BIP_W-1:0] c_window_bip = BIP_W'(1) << N;

  sc_state_t r_state;
  sc_state_t w_next_state;

  logic               w_en;
  logic               w_done;
  logic [COUNT_W-1:0] w_final_count;
  logic [BIP_W-1:0]   w_bipolar;
  logic               w_load;
  logic               w_drop;

  logic [COUNT_W-1:0]      r_count;
  logic signed [BIP_W-1:0] r_bipolar;
  logic                    r_valid;
  logic                    r_overrun;

  assign w_en = (r_state == ST_ACCUM) && bit_valid;

  sc_window_counter #(
    .N (N)
  ) u_window_counter (
    .clk           (clk),
    .reset         (reset),
    .i_clr         (start),
    .i_en          (w_en),
    .i_bit_in      (bit_in),
    .o_done        (w_done),
    .o_final_count (w_final_count)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A start on the completion cycle keeps us accumulating.
        if (w_done && !start && (CONTINUOUS == 0)) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------- result register
  // Modular arithmetic at BIP_W bits yields the two's-complement result of
  // 2*count - 2**N directly.
  assign w_bipolar = {w_final_count, 1'b0} - c_window_bip;

  // A result slot is free if empty or being drained in this same cycle.
  assign w_load = w_done && (!r_valid || out_ready);
  assign w_drop = w_done && r_valid && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_bipolar <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_count   <= w_final_count;
        r_bipolar <= $signed(w_bipolar);
        r_valid   <= 1'b1;
      end else if (out_ready) begin
        r_valid   <= 1'b0;
      end

      if (start) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign out_count   = r_count;
  assign out_bipolar = r_bipolar;
  assign out_valid   = r_valid;
  assign overrun     = r_overrun;
  assign busy        = (r_state == ST_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_stream_decoder
// Description : Directed self-checking bench for sc_stream_decoder with N=3.
//               Two instances share stimulus: u_dut0 single-shot
//               (CONTINUOUS=0), u_dut1 auto re-arm (CONTINUOUS=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_stream_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [3:0]        cnt0, cnt1;
  logic signed [4:0] bip0, bip1;
  logic              vld0, vld1, busy0, busy1, ovr0, ovr1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_stream_decoder #(.N(3), .CONTINUOUS(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_count(cnt0), .out_bipolar(bip0),
    .out_valid(vld0), .out_ready(out_ready), .busy(busy0), .overrun(ovr0)
  );

  sc_stream_decoder #(.N(3), .CONTINUOUS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_count(cnt1), .out_bipolar(bip1),
    .out_valid(vld1), .out_ready(out_ready), .busy(busy1), .overrun(ovr1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = bits[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_count", int'(cnt0), 0);
    check("rst_bip", int'(bip0), 0);
    check("rst_valid", int'(vld0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_ovr", int'(ovr0), 0);
    reset = 1'b1;
    tick();

    // Bits 1,0,1,1,0,0,1,0 -> 4 ones, bipolar 0
    pulse_start();
    check("t1_busy", int'(busy0), 1);
    send_bits(8'b0100_1101, 7);
    check("t1_valid_early", int'(vld0), 0);
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("t1_valid", int'(vld0), 1);
    check("t1_count", int'(cnt0), 4);
    check("t1_bip", int'(bip0), 0);
    check("t1_busy_done", int'(busy0), 0);
    check("t1_cont_busy", int'(busy1), 1);
    consume();
    check("t1_drained", int'(vld0), 0);

    // All ones -> 8 / +8
    pulse_start();
    send_bits(8'hFF, 8);
    check("ones_count", int'(cnt0), 8);
    check("ones_bip", int'(bip0), 8);
    consume();

    // All zeros -> 0 / -8
    pulse_start();
    send_bits(8'h00, 8);
    check("zeros_valid", int'(vld0), 1);
    check("zeros_count", int'(cnt0), 0);
    check("zeros_bip", int'(bip0), -8);
    consume();

    // bit_valid on odd cycles only, bit_in=1 throughout
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      bit_in    = 1'b1;
      bit_valid = (i % 2 == 1);
      tick();
    end
    check("sparse_valid_early", int'(vld0), 0);
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("sparse_valid", int'(vld0), 1);
    check("sparse_count", int'(cnt0), 8);
    consume();

    // Abort after 5 ones, then 8 zeros
    pulse_start();
    send_bits(8'hFF, 5);
    pulse_start();
    send_bits(8'h00, 8);
    check("abort_count", int'(cnt0), 0);
    check("abort_bip", int'(bip0), -8);
    consume();

    // Continuous, out_ready held 0 across two windows
    pulse_start();
    send_bits(8'b0000_0111, 8);
    check("cont_w1_valid", int'(vld1), 1);
    check("cont_w1_count", int'(cnt1), 3);
    check("cont_w1_ovr", int'(ovr1), 0);
    send_bits(8'hFF, 8);
    check("cont_w2_count", int'(cnt1), 3);
    check("cont_w2_bip", int'(bip1), -2);
    check("cont_w2_ovr", int'(ovr1), 1);
    check("cont_w2_busy", int'(busy1), 1);
    check("single_no_ovr", int'(ovr0), 0);
    pulse_start();
    check("start_clr_ovr", int'(ovr1), 0);
    check("start_keep_valid", int'(vld1), 1);
    check("start_keep_count", int'(cnt1), 3);

    // Consumer ready exactly on the completion cycle
    send_bits(8'hFF, 7);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    out_ready = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    out_ready = 1'b0;
    check("swap_valid", int'(vld1), 1);
    check("swap_count", int'(cnt1), 8);
    check("swap_bip", int'(bip1), 8);
    check("swap_ovr", int'(ovr1), 0);
    consume();
    check("swap_drained", int'(vld1), 0);

    // Asynchronous reset mid-window with a pending result
    pulse_start();
    send_bits(8'hFF, 8);
    pulse_start();
    send_bits(8'h05, 3);
    check("pre_rst_valid", int'(vld0), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", int'(cnt0), 0);
    check("arst_bip", int'(bip0), 0);
    check("arst_valid", int'(vld0), 0);
    check("arst_busy", int'(busy0), 0);
    check("arst_busy1", int'(busy1), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary decoder that consumes one SC bitstream, such as a neuron or tanh output.
- Counts ones over a window of 2**N valid bits and presents the count as a unipolar value and a bipolar value.
- Result goes out on a valid/ready handshake.
- Sits at the output end of SC datapaths and feeds binary logic or the host readout.

Parameters:
- N, default 8, log2 of window length; window = 2**N valid bits.
- CONTINUOUS, default 0; 1 = re-arm a new window automatically after each completion; 0 = wait for start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new window (clears accumulation).
- bit_in  in  1  stochastic bit.
- bit_valid  in  1  bit_in is sampled this cycle.
- out_count  out  N+1  number of ones in the window, 0..2**N.
- out_bipolar  out  N+2 signed  2*out_count - 2**N, range -2**N..+2**N.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  window accumulation in progress.
- overrun  out  1  sticky; a completed window was dropped because the result was unconsumed.

Behaviour:
- Reset (reset=0, async): state IDLE; sample counter = 0; ones counter = 0; out_count = 0; out_bipolar = 0; out_valid = 0; busy = 0; overrun = 0.
- States IDLE, ACCUM. The result register is independent of the state machine (double-buffered).
- IDLE: busy=0; bit_valid ignored. start=1 -> ACCUM next cycle with both counters cleared.
- ACCUM: busy=1. Each cycle with bit_valid=1: samples += 1, ones += bit_in.
- Completion: when the 2**N-th valid bit is accepted, final count = ones + bit_in.
  - If out_valid=0, or out_valid=1 and out_ready=1 that same cycle: load the result register and set out_valid=1 next cycle.
  - Otherwise: drop the result, keep the old result, set overrun=1.
- After completion: CONTINUOUS=1 -> remain in ACCUM with counters cleared, so the next valid bit is sample 0 of the new window. CONTINUOUS=0 -> go to IDLE.
- Latency: out_valid rises one cycle after the clock edge that accepts the last bit of the window.
- Handshake: out_count and out_bipolar are stable while out_valid=1 && out_ready=0. Transfer occurs on out_valid && out_ready. out_valid falls next cycle unless a new completion loads in the same cycle, in which case out_valid stays 1 with the new data.
- start during ACCUM: abort the current window, clear counters, stay in ACCUM; the pending result is unaffected.
- start on the completion cycle: the completion is processed (result loaded or dropped), then the new window begins with counters cleared.
- start always clears overrun. Otherwise overrun clears only on reset.
- Widths:
  - sample counter is N+1 bits;
  - ones counter is N+1 bits, so the all-ones window gives 2**N without wrap;
  - out_bipolar is computed from the registered out_count and is registered alongside it.
- An all-zeros window gives out_count=0, out_bipolar=-2**N.

Decomposition:
- Package sc_pkg: state enum type for IDLE/ACCUM; width helper constants (COUNT_W = N+1, BIP_W = N+2) expressed as functions of N.
- One natural sub-module: sc_window_counter, the sample and ones counters with clear and a done flag. The top level holds the FSM, the result register and the handshake.

Test Plan:
- N=3, CONTINUOUS=0: start, then 8 valid bits 1,0,1,1,0,0,1,0 -> one cycle after the 8th bit, out_valid=1, out_count=4, out_bipolar=0, busy=0.
- N=3: all-ones window -> out_count=8, out_bipolar=+8. All-zeros window -> out_count=0, out_bipolar=-8.
- N=3, bit_valid toggled every other cycle with bit_in=1 throughout -> completion only after 8 valid bits (16 cycles); invalid-cycle bits are not counted.
- CONTINUOUS=1, out_ready held 0 across two windows -> first result retained, overrun=1 after the second completion. A later start clears overrun.
- Mid-window start after 5 bits, then 8 zeros -> out_count=0. Reset asserted mid-window -> all outputs 0 immediately, asynchronously.
- CONTINUOUS=1 with out_ready=1 exactly on a completion cycle -> out_valid stays 1, carrying the new count, with no overrun.
